// File: rtl/demux2_stream_pkg.sv
// Shared definitions for the two-way packet demultiplexer: FSM encoding,
// default widths and the routing helper used by the top level.
package demux2_stream_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNTW  = 16;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ROUTE0 = 2'b01;
  localparam logic [1:0] ST_ROUTE1 = 2'b10;

  // A packet start follows sel; an open packet stays on the port it started on.
  function automatic logic route_target(input logic [1:0] state, input logic sel);
    return (state == ST_IDLE) ? sel : (state == ST_ROUTE1);
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register for a demux port, plus a saturating count of
// beats handed to the downstream consumer.
module demux_out_slot
  import demux2_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic [CNTW-1:0]  o_cnt,
  output logic             o_can_load
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_last;
  logic [CNTW-1:0]  r_cnt;

  // NOTE: payload registers are reset too, so the outputs read a defined zero
  // after reset instead of stale data from a discarded packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, whatever the statement order.
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_valid && i_ready && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_last     = r_last;
  assign o_cnt      = r_cnt;
  assign o_can_load = !r_valid || i_ready;

endmodule

// File: rtl/demux2_stream.sv
// Packet-aware 1-to-2 stream demultiplexer: a packet's first beat picks the
// port via sel, and the remaining beats follow it until s_last.
module demux2_stream
  import demux2_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sel,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m0_valid,
  input  logic             m0_ready,
  output logic [WIDTH-1:0] m0_data,
  output logic             m0_last,
  output logic             m1_valid,
  input  logic             m1_ready,
  output logic [WIDTH-1:0] m1_data,
  output logic             m1_last,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       w_target;
  logic       w_can0;
  logic       w_can1;
  logic       w_accept;

  assign w_target = route_target(r_state, sel);
  // Gated by reset so nothing is accepted while the slots are held clear.
  assign s_ready  = reset_n && (w_target ? w_can1 : w_can0);
  assign w_accept = s_valid && s_ready;

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept && !s_last) w_next = sel ? ST_ROUTE1 : ST_ROUTE0;
      ST_ROUTE0,
      ST_ROUTE1: if (w_accept && s_last) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  demux_out_slot #(.WIDTH(WIDTH), .CNTW(CNTW)) u_slot0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_accept && !w_target),
    .i_data     (s_data),
    .i_last     (s_last),
    .i_ready    (m0_ready),
    .o_valid    (m0_valid),
    .o_data     (m0_data),
    .o_last     (m0_last),
    .o_cnt      (cnt0),
    .o_can_load (w_can0)
  );

  demux_out_slot #(.WIDTH(WIDTH), .CNTW(CNTW)) u_slot1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_accept && w_target),
    .i_data     (s_data),
    .i_last     (s_last),
    .i_ready    (m1_ready),
    .o_valid    (m1_valid),
    .o_data     (m1_data),
    .o_last     (m1_last),
    .o_cnt      (cnt1),
    .o_can_load (w_can1)
  );

endmodule

// File: tb/tb_demux2_stream.sv
// Directed bench for demux2_stream with a per-port scoreboard; CNTW is set to
// 2 so counter saturation is reachable in a few beats.
module tb_demux2_stream;

  localparam int W  = 8;
  localparam int CW = 2;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sel;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          s_last;
  logic          m0_valid, m0_ready, m0_last;
  logic          m1_valid, m1_ready, m1_last;
  logic [W-1:0]  m0_data, m1_data;
  logic [CW-1:0] cnt0, cnt1;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;

  demux2_stream #(.WIDTH(W), .CNTW(CW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sel      (sel),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m0_valid (m0_valid),
    .m0_ready (m0_ready),
    .m0_data  (m0_data),
    .m0_last  (m0_last),
    .m1_valid (m1_valid),
    .m1_ready (m1_ready),
    .m1_data  (m1_data),
    .m1_last  (m1_last),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one beat from posedge+1 and returns at posedge+1 after acceptance.
  task automatic send(input logic s, input logic [W-1:0] d, input logic l, input int port);
    logic ok;
    beat_t b;
    ok = 1'b0;
    sel = s; s_data = d; s_last = l; s_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accepted", 32'(ok), 32'd1);
    if (ok) begin
      b.data = d;
      b.last = l;
      if (port == 0) q0.push_back(b);
      else           q1.push_back(b);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    #1;
    check("rst_m0_valid", 32'(m0_valid), 32'd0);
    check("rst_m1_valid", 32'(m1_valid), 32'd0);
    check("rst_cnt0", 32'(cnt0), 32'd0);
    check("rst_cnt1", 32'(cnt1), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Scoreboard: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (m0_valid && m0_ready) begin
        n_tests++;
        assert (q0.size() != 0) else begin
          n_fail++;
          $error("FAIL m0_unexpected: observed data 0x%0h with no beat expected", m0_data);
        end
        if (q0.size() != 0) begin
          beat_t e0;
          e0 = q0.pop_front();
          check("m0_data", 32'(m0_data), 32'(e0.data));
          check("m0_last", 32'(m0_last), 32'(e0.last));
          exp_cnt0 = (exp_cnt0 == CNT_SAT) ? CNT_SAT : exp_cnt0 + 1;
        end
      end
      if (m1_valid && m1_ready) begin
        n_tests++;
        assert (q1.size() != 0) else begin
          n_fail++;
          $error("FAIL m1_unexpected: observed data 0x%0h with no beat expected", m1_data);
        end
        if (q1.size() != 0) begin
          beat_t e1;
          e1 = q1.pop_front();
          check("m1_data", 32'(m1_data), 32'(e1.data));
          check("m1_last", 32'(m1_last), 32'(e1.last));
          exp_cnt1 = (exp_cnt1 == CNT_SAT) ? CNT_SAT : exp_cnt1 + 1;
        end
      end
    end
  end

  initial begin
    int t0;
    reset_n = 1'b0; sel = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    m0_ready = 1'b1; m1_ready = 1'b1;
    #1;
    check("por_s_ready", 32'(s_ready), 32'd0);
    check("por_m0_valid", 32'(m0_valid), 32'd0);
    check("por_m1_valid", 32'(m1_valid), 32'd0);
    check("por_m0_last", 32'(m0_last), 32'd0);
    check("por_m0_data", 32'(m0_data), 32'd0);
    check("por_cnt0", 32'(cnt0), 32'd0);
    check("por_cnt1", 32'(cnt1), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat packets on each port, one-cycle latency.
    send(1'b0, 8'h11, 1'b1, 0);
    check("sb_m0_valid", 32'(m0_valid), 32'd1);
    check("sb_m0_data", 32'(m0_data), 32'h11);
    send(1'b1, 8'h22, 1'b1, 1);
    check("sb_m1_valid", 32'(m1_valid), 32'd1);
    check("sb_m1_data", 32'(m1_data), 32'h22);
    check("sb_m0_drained", 32'(m0_valid), 32'd0);
    @(posedge clk); #1;
    check("sb_cnt0", 32'(cnt0), 32'd1);
    check("sb_cnt1", 32'(cnt1), 32'd1);

    // Packet lock: sel flips mid-packet, all beats stay on port 0.
    send(1'b0, 8'hA1, 1'b0, 0);
    send(1'b1, 8'hA2, 1'b0, 0);
    send(1'b1, 8'hA3, 1'b1, 0);
    check("lock_m1_idle", 32'(m1_valid), 32'd0);
    check("lock_m0_data", 32'(m0_data), 32'hA3);
    repeat (2) begin @(posedge clk); #1; end
    check("lock_cnt0", 32'(cnt0), 32'(exp_cnt0));
    check("lock_cnt1", 32'(cnt1), 32'(exp_cnt1));

    // Backpressure on port 0, then simultaneous drain and load.
    m0_ready = 1'b0;
    send(1'b0, 8'h55, 1'b1, 0);
    sel = 1'b0; s_data = 8'h66; s_last = 1'b1; s_valid = 1'b1;
    #1;
    check("bp_s_ready_low", 32'(s_ready), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    check("bp_m0_valid_hold", 32'(m0_valid), 32'd1);
    check("bp_m0_data_hold", 32'(m0_data), 32'h55);
    check("bp_s_ready_still_low", 32'(s_ready), 32'd0);
    m0_ready = 1'b1;
    #1;
    check("bp_s_ready_release", 32'(s_ready), 32'd1);
    send(1'b0, 8'h66, 1'b1, 0);
    check("bp_reload_valid", 32'(m0_valid), 32'd1);
    check("bp_reload_data", 32'(m0_data), 32'h66);

    // Port 1 stalled while port 0 streams at full rate.
    m1_ready = 1'b0;
    send(1'b1, 8'h77, 1'b1, 1);
    t0 = cyc;
    send(1'b0, 8'hB0, 1'b0, 0);
    send(1'b0, 8'hB1, 1'b0, 0);
    send(1'b0, 8'hB2, 1'b0, 0);
    send(1'b0, 8'hB3, 1'b1, 0);
    check("ind_cycles", 32'(cyc - t0), 32'd4);
    check("ind_m1_valid", 32'(m1_valid), 32'd1);
    check("ind_m1_data", 32'(m1_data), 32'h77);
    check("ind_cnt0", 32'(cnt0), 32'(exp_cnt0));
    m1_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("ind_cnt1", 32'(cnt1), 32'(exp_cnt1));

    // Counter saturation on port 1.
    pulse_reset();
    for (int i = 0; i < 5; i++) send(1'b1, 8'hC0 + 8'(i), 1'b1, 1);
    repeat (2) begin @(posedge clk); #1; end
    check("sat_cnt1", 32'(cnt1), 32'd3);
    check("sat_cnt0", 32'(cnt0), 32'd0);

    // Reset in the middle of a port-1 packet.
    send(1'b1, 8'hD1, 1'b0, 1);
    send(1'b1, 8'hD2, 1'b0, 1);
    pulse_reset();
    send(1'b0, 8'hE0, 1'b1, 0);
    check("rst_pkt_m0_valid", 32'(m0_valid), 32'd1);
    check("rst_pkt_m0_data", 32'(m0_data), 32'hE0);
    check("rst_pkt_m1_valid", 32'(m1_valid), 32'd0);

    repeat (3) begin @(posedge clk); #1; end
    check("end_q0_empty", 32'(q0.size()), 32'd0);
    check("end_q1_empty", 32'(q1.size()), 32'd0);
    check("end_cnt0", 32'(cnt0), 32'(exp_cnt0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux2_stream.md
DEMUX2_STREAM -- requirements
Module: demux2_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter CNTW, default 16, beat-counter width.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 sel  input  1  route select (0 to port 0, 1 to port 1), sampled on a packet's first beat.
REQ-006 s_valid  input  1  upstream beat valid.
REQ-007 s_ready  output  1  upstream beat accepted when s_valid && s_ready.
REQ-008 s_data  input  WIDTH  upstream payload.
REQ-009 s_last  input  1  final beat of packet.
REQ-010 m0_valid/m1_valid  output  1  downstream beat valid, per port.
REQ-011 m0_ready/m1_ready  input  1  downstream accept, per port.
REQ-012 m0_data/m1_data  output  WIDTH  downstream payload.
REQ-013 m0_last/m1_last  output  1  downstream last flag.
REQ-014 cnt0/cnt1  output  CNTW  saturating count of beats delivered on each port.

Function
REQ-015 FSM states: IDLE (no packet open), ROUTE0, ROUTE1.
REQ-016 IDLE: accepted beat with sel=0 goes to ROUTE0, sel=1 goes to ROUTE1; if that beat has s_last=1, stay in IDLE.
REQ-017 ROUTE0/ROUTE1: sel ignored; accepted beat with s_last=1 returns to IDLE.
REQ-018 Each port has a one-entry output register holding valid/data/last.
REQ-019 Target port = sel in IDLE, locked port otherwise; s_ready = !mX_valid || mX_ready of the target port, combinational.
REQ-020 Latency: beat accepted at edge N is visible on mX outputs after edge N (one cycle); back-to-back throughput of 1 beat/clk while mX_ready=1.
REQ-021 Non-target port register unaffected by upstream traffic; it drains independently on its own ready.
REQ-022 mX_valid, once high, SHALL hold with data/last stable until mX_ready=1.
REQ-023 Simultaneous drain and load on the same port in one cycle: register takes the new beat, valid stays 1.
REQ-024 cntX increments on each mX_valid && mX_ready; saturates at all-ones, no wrap.
REQ-025 No beat SHALL be duplicated, dropped or reordered within a port.
REQ-026 sel change mid-packet SHALL NOT split a packet across ports.

Reset
REQ-027 reset_n low: FSM=IDLE, m0_valid=m1_valid=0, m0_last=m1_last=0, data registers=0, cnt0=cnt1=0, asynchronously.
REQ-028 Reset mid-packet discards the open packet and any buffered beats; the first beat after release is treated as a packet start.
REQ-029 s_ready SHALL be 0 while reset_n is low.

Structure
REQ-030 Shared package SHALL hold the FSM state encoding (IDLE=2'b00, ROUTE0=2'b01, ROUTE1=2'b10) and the default WIDTH/CNTW.
REQ-031 The per-port output register plus counter SHALL be one sub-module, demux_out_slot, instantiated twice.

Verification
REQ-032 Single-beat packets, both readys=1: sel=0 data 0x11 last=1, then sel=1 data 0x22 last=1 -> m0 shows 0x11 one cycle later, m1 shows 0x22 the next cycle, cnt0=cnt1=1.
REQ-033 Packet lock: 3-beat packet 0xA1,0xA2,0xA3 with sel=0 on beat 1 and sel=1 on beats 2-3 -> all three beats on m0, none on m1.
REQ-034 Backpressure: m0_ready=0 with beat 0x55 held -> s_ready=0 for the next port-0 beat, m0_data stays 0x55; m0_ready=1 -> beat drains, s_ready=1 in the same cycle.
REQ-035 Independent drain: m1 holding 0x77 with m1_ready=0 while 4 beats stream to port 0 at m0_ready=1 -> 4 beats/4 clks on m0, m1 still 0x77.
REQ-036 Saturation with CNTW=2: 5 beats delivered on port 1 -> cnt1 reads 3.
REQ-037 Reset mid-packet: reset_n pulsed low after beat 2 of a 4-beat sel=1 packet -> m1_valid=0 and cnt1=0 immediately; next beat with sel=0 lands on m0.
